// File: rtl/arithmetic_pipeline_param.sv
// arithmetic_pipeline_param
// Single-issue 6502 ALU pipeline with configurable width and depth.
// One micro-op is evaluated combinationally at the input, registered into
// stage 1, then shifted through STAGES-1 further registers. The last stage
// drives the writeback/CDB side. ROB entry and both register tags travel
// alongside the data. A flush kills everything in flight, plus any input
// presented in the same cycle.
//
// Handshake (both sides): a transfer happens on a rising edge where
// valid && ready are both high. The producer holds valid and payload stable
// until it transfers. The pipeline raises instr_ready whenever it can move,
// meaning the last stage is empty or being retired this cycle. A stall
// freezes every stage; bubbles are not squeezed out.
module arithmetic_pipeline_param #(
  parameter int WIDTH  = 8,
  parameter int TAG_W  = 5,
  parameter int REG_W  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             flush,
  input  logic [3:0]       opcode,
  input  logic [TAG_W-1:0] ROB_entry,
  input  logic [REG_W-1:0] dest_reg,
  input  logic [REG_W-1:0] flag_reg,
  input  logic [WIDTH-1:0] op_a_val,
  input  logic [WIDTH-1:0] op_b_val,
  input  logic [7:0]       flags_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] ROB_entry_out,
  output logic [REG_W-1:0] dest_reg_out,
  output logic [REG_W-1:0] flag_reg_out,
  output logic [WIDTH-1:0] result_val,
  output logic [7:0]       result_flags
);

  localparam int MSB = WIDTH - 1;

  // P register bit positions (NV1BDIZC). Bits 5..2 are never touched here.
  localparam int FL_C = 0;
  localparam int FL_Z = 1;
  localparam int FL_V = 6;
  localparam int FL_N = 7;

  typedef enum logic [3:0] {
    OP_ADC  = 4'h0,
    OP_SBC  = 4'h1,
    OP_AND  = 4'h2,
    OP_ORA  = 4'h3,
    OP_EOR  = 4'h4,
    OP_ASL  = 4'h5,
    OP_LSR  = 4'h6,
    OP_ROL  = 4'h7,
    OP_ROR  = 4'h8,
    OP_INC  = 4'h9,
    OP_DEC  = 4'hA,
    OP_CMP  = 4'hB,
    OP_BIT  = 4'hC,
    OP_PASS = 4'hD
  } alu_op_e;

  // ---------------------------------------------------------------------
  // ALU: pure function of the presented operands and incoming flags.
  // ---------------------------------------------------------------------
  logic             c_in;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             add_ovf;
  logic [WIDTH-1:0] alu_res;
  logic [7:0]       alu_flags;
  logic             set_nz;

  // Shared adder serves ADC and SBC (SBC adds the complement of B with C
  // as the "no borrow" input). CMP uses its own subtractor so its carry
  // means a >= b independent of the incoming C.
  always_comb begin
    c_in      = flags_val[FL_C];
    add_b     = (opcode == OP_SBC) ? ~op_b_val : op_b_val;
    sum       = {1'b0, op_a_val} + {1'b0, add_b} + {{WIDTH{1'b0}}, c_in};
    diff      = {1'b0, op_a_val} - {1'b0, op_b_val};
    add_ovf   = (op_a_val[MSB] == add_b[MSB]) && (sum[MSB] != op_a_val[MSB]);
    alu_res   = op_a_val;
    alu_flags = flags_val;
    set_nz    = 1'b0;
    case (opcode)
      OP_ADC, OP_SBC: begin
        alu_res         = sum[MSB:0];
        alu_flags[FL_C] = sum[WIDTH];
        alu_flags[FL_V] = add_ovf;
        set_nz          = 1'b1;
      end
      OP_AND: begin
        alu_res = op_a_val & op_b_val;
        set_nz  = 1'b1;
      end
      OP_ORA: begin
        alu_res = op_a_val | op_b_val;
        set_nz  = 1'b1;
      end
      OP_EOR: begin
        alu_res = op_a_val ^ op_b_val;
        set_nz  = 1'b1;
      end
      OP_ASL: begin
        alu_res         = {op_a_val[MSB-1:0], 1'b0};
        alu_flags[FL_C] = op_a_val[MSB];
        set_nz          = 1'b1;
      end
      OP_LSR: begin
        alu_res         = {1'b0, op_a_val[MSB:1]};
        alu_flags[FL_C] = op_a_val[0];
        set_nz          = 1'b1;
      end
      OP_ROL: begin
        alu_res         = {op_a_val[MSB-1:0], c_in};
        alu_flags[FL_C] = op_a_val[MSB];
        set_nz          = 1'b1;
      end
      OP_ROR: begin
        alu_res         = {c_in, op_a_val[MSB:1]};
        alu_flags[FL_C] = op_a_val[0];
        set_nz          = 1'b1;
      end
      OP_INC: begin
        alu_res = op_a_val + WIDTH'(1);
        set_nz  = 1'b1;
      end
      OP_DEC: begin
        alu_res = op_a_val - WIDTH'(1);
        set_nz  = 1'b1;
      end
      OP_CMP: begin
        // Result register keeps A; flags come from the trial subtraction.
        alu_flags[FL_C] = ~diff[WIDTH];
        alu_flags[FL_N] = diff[MSB];
        alu_flags[FL_Z] = (diff[MSB:0] == '0);
      end
      OP_BIT: begin
        alu_flags[FL_Z] = ((op_a_val & op_b_val) == '0);
        alu_flags[FL_N] = op_b_val[MSB];
        alu_flags[FL_V] = op_b_val[MSB-1];
      end
      OP_PASS: begin
        alu_res = op_b_val;
        set_nz  = 1'b1;
      end
      default: begin
        // Reserved opcodes: A passes through, flags untouched.
        alu_res = op_a_val;
      end
    endcase
    if (set_nz) begin
      alu_flags[FL_N] = alu_res[MSB];
      alu_flags[FL_Z] = (alu_res == '0);
    end
  end

  // ---------------------------------------------------------------------
  // Pipeline registers. Index 0 is stage 1, STAGES-1 is the output stage.
  // ---------------------------------------------------------------------
  logic [STAGES-1:0] vld_q;
  logic [TAG_W-1:0]  rob_q   [STAGES];
  logic [REG_W-1:0]  dst_q   [STAGES];
  logic [REG_W-1:0]  frg_q   [STAGES];
  logic [WIDTH-1:0]  res_q   [STAGES];
  logic [7:0]        flg_q   [STAGES];
  logic              adv;

  // The whole chain moves unless the output holds an entry nobody takes.
  assign adv         = !(out_valid && !out_ready);
  assign instr_ready = adv;

  // Valid chain and payload chain; flush wins over both accept and retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        rob_q[i] <= '0;
        dst_q[i] <= '0;
        frg_q[i] <= '0;
        res_q[i] <= '0;
        flg_q[i] <= '0;
      end
    end else if (flush) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q[0] <= instr_valid;
      if (instr_valid) begin
        rob_q[0] <= ROB_entry;
        dst_q[0] <= dest_reg;
        frg_q[0] <= flag_reg;
        res_q[0] <= alu_res;
        flg_q[0] <= alu_flags;
      end
      for (int i = 1; i < STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
        rob_q[i] <= rob_q[i-1];
        dst_q[i] <= dst_q[i-1];
        frg_q[i] <= frg_q[i-1];
        res_q[i] <= res_q[i-1];
        flg_q[i] <= flg_q[i-1];
      end
    end
  end

  assign out_valid     = vld_q[STAGES-1];
  assign ROB_entry_out = rob_q[STAGES-1];
  assign dest_reg_out  = dst_q[STAGES-1];
  assign flag_reg_out  = frg_q[STAGES-1];
  assign result_val    = res_q[STAGES-1];
  assign result_flags  = flg_q[STAGES-1];

endmodule

// File: tb/tb_arithmetic_pipeline_param.sv
// Bench for arithmetic_pipeline_param: an 8-bit / 2-stage instance for the
// directed cases and a randomized run, and a 16-bit / 1-stage instance for
// the wide-overflow and single-cycle-latency case.
module tb_arithmetic_pipeline_param;

  localparam int W = 31; // {rob, dest, flag_reg, result, flags}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- 8-bit, 2-stage instance ----------------
  logic       iv8, ir8, fl8, ov8, or8;
  logic [3:0] op8;
  logic [4:0] rob8, dst8, frg8, robo8, dsto8, frgo8;
  logic [7:0] a8, b8, f8, res8, flo8;

  arithmetic_pipeline_param #(.WIDTH(8), .TAG_W(5), .REG_W(5), .STAGES(2)) u8 (
    .clk(clk), .rst(rst),
    .instr_valid(iv8), .instr_ready(ir8), .flush(fl8), .opcode(op8),
    .ROB_entry(rob8), .dest_reg(dst8), .flag_reg(frg8),
    .op_a_val(a8), .op_b_val(b8), .flags_val(f8),
    .out_valid(ov8), .out_ready(or8),
    .ROB_entry_out(robo8), .dest_reg_out(dsto8), .flag_reg_out(frgo8),
    .result_val(res8), .result_flags(flo8)
  );

  // ---------------- 16-bit, 1-stage instance ----------------
  logic        iv16, ir16, fl16, ov16, or16;
  logic [3:0]  op16;
  logic [4:0]  rob16, dst16, frg16, robo16, dsto16, frgo16;
  logic [15:0] a16, b16, res16;
  logic [7:0]  f16, flo16;

  arithmetic_pipeline_param #(.WIDTH(16), .TAG_W(5), .REG_W(5), .STAGES(1)) u16 (
    .clk(clk), .rst(rst),
    .instr_valid(iv16), .instr_ready(ir16), .flush(fl16), .opcode(op16),
    .ROB_entry(rob16), .dest_reg(dst16), .flag_reg(frg16),
    .op_a_val(a16), .op_b_val(b16), .flags_val(f16),
    .out_valid(ov16), .out_ready(or16),
    .ROB_entry_out(robo16), .dest_reg_out(dsto16), .flag_reg_out(frgo16),
    .result_val(res16), .result_flags(flo16)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the 6502 rules.
  // Returns {flags[7:0], result[15:0]}.
  function automatic logic [23:0] ref_alu(input int w, input int op, input int a,
                                          input int b, input int f);
    int mask, msb, c, r, nf, s, sv, t, nb;
    bit nz;
    mask = (1 << w) - 1;
    msb  = 1 << (w - 1);
    c    = f & 1;
    nf   = f;
    r    = a;
    nz   = 1'b1;
    case (op)
      0: begin
        s  = a + b + c;
        r  = s & mask;
        sv = sx(w, a) + sx(w, b) + c;
        nf = (nf & ~8'h41) | ((s > mask) ? 1 : 0) | ((sv >= msb || sv < -msb) ? 8'h40 : 0);
      end
      1: begin
        nb = (~b) & mask;
        s  = a + nb + c;
        r  = s & mask;
        sv = sx(w, a) - sx(w, b) - (1 - c);
        nf = (nf & ~8'h41) | ((s > mask) ? 1 : 0) | ((sv >= msb || sv < -msb) ? 8'h40 : 0);
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a << 1) & mask; nf = (nf & ~1) | ((a & msb) != 0 ? 1 : 0); end
      6: begin r = a >> 1;          nf = (nf & ~1) | (a & 1); end
      7: begin r = ((a << 1) | c) & mask; nf = (nf & ~1) | ((a & msb) != 0 ? 1 : 0); end
      8: begin r = (a >> 1) | (c != 0 ? msb : 0); nf = (nf & ~1) | (a & 1); end
      9: r = (a + 1) & mask;
      10: r = (a - 1) & mask;
      11: begin
        nz = 1'b0;
        t  = (a - b) & mask;
        nf = (nf & ~8'h83) | (a >= b ? 1 : 0) | ((t & msb) != 0 ? 8'h80 : 0)
             | (t == 0 ? 2 : 0);
      end
      12: begin
        nz = 1'b0;
        nf = (nf & ~8'hC2) | ((a & b) == 0 ? 2 : 0) | ((b & msb) != 0 ? 8'h80 : 0)
             | ((b & (msb >> 1)) != 0 ? 8'h40 : 0);
      end
      13: r = b;
      default: nz = 1'b0;
    endcase
    if (nz) nf = (nf & ~8'h82) | ((r & msb) != 0 ? 8'h80 : 0) | (r == 0 ? 2 : 0);
    return {nf[7:0], r[15:0]};
  endfunction

  function automatic int sx(input int w, input int v);
    return ((v >> (w - 1)) & 1) != 0 ? v - (1 << w) : v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] f);
    iv8 = 1'b1; op8 = op; a8 = a; b8 = b; f8 = f;
  endtask

  // Issue one op into an idle 8-bit pipe and check latency, result, flags.
  task automatic run_dir(input string tag, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] f,
                         input logic [7:0] er, input logic [7:0] ef);
    or8 = 1'b1;
    issue8(op, a, b, f);
    step();
    iv8 = 1'b0;
    check({tag, "_lat1"}, ov8, 1'b0);
    step();
    check({tag, "_valid"}, ov8, 1'b1);
    check({tag, "_res"}, res8, er);
    check({tag, "_flags"}, flo8, ef);
    step();
  endtask

  logic [23:0]  m;
  logic [W-1:0] e;

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    iv8 = 0; fl8 = 0; or8 = 0; op8 = 0; rob8 = 0; dst8 = 0; frg8 = 0; a8 = 0; b8 = 0; f8 = 0;
    iv16 = 0; fl16 = 0; or16 = 0; op16 = 0; rob16 = 0; dst16 = 0; frg16 = 0;
    a16 = 0; b16 = 0; f16 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ov", ov8, 1'b0);
    check("rst_res", {robo8, dsto8, frgo8, res8, flo8}, 31'd0);
    rst = 1'b0;
    step();
    check("post_rst_ov", ov8, 1'b0);
    check("post_rst_ready", ir8, 1'b1);
    check("post_rst_data", {robo8, dsto8, frgo8, res8, flo8}, 31'd0);

    // ADC with tags
    rob8 = 5'h01; dst8 = 5'h02; frg8 = 5'h0F;
    or8 = 1'b1;
    issue8(4'h0, 8'h50, 8'h50, 8'h20);
    step();
    iv8 = 1'b0;
    check("adc_lat1", ov8, 1'b0);
    step();
    check("adc_valid", ov8, 1'b1);
    check("adc_res", res8, 8'hA0);
    check("adc_flags", flo8, 8'hE0);
    check("adc_tags", {robo8, dsto8, frgo8}, {5'h01, 5'h02, 5'h0F});
    step();
    check("adc_retired", ov8, 1'b0);

    run_dir("sbc", 4'h1, 8'h05, 8'h05, 8'h21, 8'h00, 8'h23);
    run_dir("cmp", 4'hB, 8'h10, 8'h20, 8'h00, 8'h10, 8'h80);
    run_dir("ror", 4'h8, 8'h01, 8'h00, 8'h01, 8'h80, 8'h81);
    run_dir("bit", 4'hC, 8'h0F, 8'hC0, 8'h00, 8'h0F, 8'hC2);
    run_dir("rsv", 4'hE, 8'h00, 8'h12, 8'h3C, 8'h00, 8'h3C);

    // Back-pressure: three back-to-back ADCs with the consumer stalled
    or8 = 1'b0;
    issue8(4'h0, 8'd1, 8'd0, 8'h00);
    step();
    issue8(4'h0, 8'd2, 8'd0, 8'h00);
    step();
    issue8(4'h0, 8'd3, 8'd0, 8'h00);
    check("bp_ov", ov8, 1'b1);
    check("bp_hold_res", res8, 8'd1);
    check("bp_ready", ir8, 1'b0);
    step();
    check("bp_hold_res2", res8, 8'd1);
    check("bp_ready2", ir8, 1'b0);
    or8 = 1'b1;
    step();
    iv8 = 1'b0;
    check("bp_out2", {ov8, res8}, {1'b1, 8'd2});
    step();
    check("bp_out3", {ov8, res8}, {1'b1, 8'd3});
    step();
    check("bp_empty", ov8, 1'b0);

    // Flush with two in flight and a new input in the same cycle
    or8 = 1'b0;
    issue8(4'h0, 8'd7, 8'd0, 8'h00);
    step();
    issue8(4'h0, 8'd8, 8'd0, 8'h00);
    step();
    issue8(4'h0, 8'd9, 8'd0, 8'h00);
    fl8 = 1'b1;
    step();
    fl8 = 1'b0; iv8 = 1'b0; or8 = 1'b1;
    check("flush_ov", ov8, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("flush_quiet", ov8, 1'b0);
    end

    // 16-bit, single-stage: signed overflow, one-cycle latency
    or16 = 1'b1; iv16 = 1'b1; op16 = 4'h0; a16 = 16'h7FFF; b16 = 16'h0001; f16 = 8'h20;
    rob16 = 5'h11; dst16 = 5'h12; frg16 = 5'h13;
    step();
    iv16 = 1'b0;
    check("w16_valid", ov16, 1'b1);
    check("w16_res", res16, 16'h8000);
    check("w16_flags", flo16, 8'hE0);
    check("w16_tags", {robo16, dsto16, frgo16}, {5'h11, 5'h12, 5'h13});
    m = ref_alu(16, 0, 16'h7FFF, 1, 8'h20);
    check("w16_model", {flo16, res16}, m);
    step();
    check("w16_retired", ov16, 1'b0);

    // Randomized run against the reference model
    for (int cyc = 0; cyc < 600; cyc++) begin
      iv8  = ($urandom_range(0, 3) != 0);
      op8  = 4'($urandom_range(0, 15));
      a8   = 8'($urandom_range(0, 255));
      b8   = 8'($urandom_range(0, 255));
      f8   = 8'($urandom_range(0, 255));
      rob8 = 5'($urandom_range(0, 31));
      dst8 = 5'($urandom_range(0, 31));
      frg8 = 5'($urandom_range(0, 31));
      or8  = ($urandom_range(0, 3) != 0);
      fl8  = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      check("rand_ready", ir8, !(ov8 && !or8));
      if (!fl8 && ov8 && or8) begin
        if (exp_q.size() == 0) check("rand_spurious", ov8, 1'b0);
        else begin
          e = exp_q.pop_front();
          check("rand_out", {robo8, dsto8, frgo8, res8, flo8}, e);
        end
      end
      if (fl8) exp_q.delete();
      else if (iv8 && ir8) begin
        m = ref_alu(8, int'(op8), int'(a8), int'(b8), int'(f8));
        exp_q.push_back({rob8, dst8, frg8, m[7:0], m[23:16]});
      end
      @(posedge clk);
      #1;
    end

    // Drain, bounded
    iv8 = 1'b0; fl8 = 1'b0; or8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov8) begin
        if (exp_q.size() == 0) check("drain_spurious", ov8, 1'b0);
        else begin
          e = exp_q.pop_front();
          check("drain_out", {robo8, dsto8, frgo8, res8, flo8}, e);
        end
      end
      @(posedge clk);
      #1;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    check("drain_ov", ov8, 1'b0);

    // Asynchronous reset mid-stream with a result waiting
    or8 = 1'b0;
    issue8(4'h3, 8'h5A, 8'h0F, 8'h00);
    rob8 = 5'h1F; dst8 = 5'h1E; frg8 = 5'h1D;
    step();
    iv8 = 1'b0;
    step();
    check("midrst_pre_ov", ov8, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_ov", ov8, 1'b0);
    check("midrst_data", {robo8, dsto8, frgo8, res8, flo8}, 31'd0);
    step();
    rst = 1'b0;
    step();
    check("midrst_after", {ov8, res8, flo8}, 17'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
